// File: rtl/sha_pkg.sv
// Shared types and constants for the SHA-256 core arbiter slice.
// Holds the sequencer state encoding and the round-robin pointer helper.
package sha_pkg;

   localparam int SHA_BLOCK_W  = 512;
   localparam int SHA_DIGEST_W = 256;
   localparam int SHA_MAX_REQ  = 4;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      WAIT,
      DONE
   } arbState_t;

   // Next requester index, wrapping at the configured requester count
   function automatic logic [1:0] rrNext(input logic [1:0] cur, input int numReq);
      return (cur == 2'(numReq - 1)) ? 2'd0 : cur + 2'd1;
   endfunction

endpackage

// File: rtl/sha_core_arbiter_rr_pick.sv
// Combinational round-robin picker: searches upward from pointer+1, wrapping,
// and returns a one-hot grant, the winner index and an any-request flag.
module rr_pick
   import sha_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] iReq,
   input  logic [1:0]         iPtr,
   output logic [NUM_REQ-1:0] oGrant,
   output logic [1:0]         oIdx,
   output logic               oAny
);

   logic [SHA_MAX_REQ-1:0] reqExt;
   logic [1:0]             cand;

   assign reqExt = SHA_MAX_REQ'(iReq);

   always_comb begin
      oGrant = '0;
      oIdx   = '0;
      oAny   = 1'b0;
      cand   = iPtr;
      for (int off = 0; off < NUM_REQ; off++) begin
         cand = rrNext(cand, NUM_REQ);
         if (!oAny && reqExt[cand]) begin
            oAny = 1'b1;
            oIdx = cand;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         oGrant[i] = oAny && (oIdx == 2'(i));
      end
   end

endmodule

// File: rtl/sha_core_arbiter.sv
// Round-robin arbiter/sequencer sharing one sha_core between NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining SHA_ARB_TIMEOUT_EN.
module sha_core_arbiter
   import sha_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                           iClk,
   input  logic                           iReset_n,
   input  logic [NUM_REQ-1:0]             iReq,
   input  logic [NUM_REQ*SHA_BLOCK_W-1:0] iMsg,
   output logic [NUM_REQ-1:0]             oGrant,
   output logic [NUM_REQ-1:0]             oDone,
   output logic [SHA_DIGEST_W-1:0]        oHash,
   output logic                           oBusy,
   output logic                           oTimeout,
   output logic                           oCoreStart,
   output logic [SHA_BLOCK_W-1:0]         oCoreMessage,
   input  logic [SHA_DIGEST_W-1:0]        iCoreHash,
   input  logic                           iCoreValid
);

   if (NUM_REQ < 2 || NUM_REQ > SHA_MAX_REQ || TIMEOUT_CYCLES < 1) begin : gBadParam
      $error("sha_core_arbiter: illegal NUM_REQ or TIMEOUT_CYCLES");
   end

   arbState_t          state, stateNext;
   logic [1:0]         ptr, winIdx, pickIdx;
   logic [NUM_REQ-1:0] pickGrant;
   logic               pickAny;
   logic               blank;
   logic               timeoutFlag;
   logic               validHit, timeoutHit;

   rr_pick #(.NUM_REQ(NUM_REQ)) uPick (
      .iReq   (iReq),
      .iPtr   (ptr),
      .oGrant (pickGrant),
      .oIdx   (pickIdx),
      .oAny   (pickAny)
   );

   // First WAIT cycle is blanked so a level valid from the last hash is ignored
   assign validHit = (state == WAIT) && !blank && iCoreValid;

`ifdef SHA_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] waitCnt;

   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         waitCnt <= '0;
      end else if (state == START) begin
         waitCnt <= '0;
      end else if (state == WAIT) begin
         waitCnt <= waitCnt + CNT_W'(1);
      end
   end

   assign timeoutHit = (state == WAIT) && !validHit && (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeoutHit = 1'b0;
`endif

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (pickAny) stateNext = LOAD;
         LOAD:    stateNext = START;
         START:   stateNext = WAIT;
         WAIT:    if (validHit || timeoutHit) stateNext = DONE;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         state        <= IDLE;
         ptr          <= 2'(NUM_REQ - 1);
         winIdx       <= '0;
         oGrant       <= '0;
         oCoreMessage <= '0;
         oHash        <= '0;
         blank        <= 1'b0;
         timeoutFlag  <= 1'b0;
      end else begin
         state <= stateNext;
         case (state)
            IDLE: begin
               if (pickAny) begin
                  winIdx <= pickIdx;
                  oGrant <= pickGrant;
               end
            end
            LOAD:  oCoreMessage <= iMsg[int'(winIdx)*SHA_BLOCK_W +: SHA_BLOCK_W];
            START: blank <= 1'b1;
            WAIT: begin
               blank <= 1'b0;
               if (validHit) begin
                  oHash       <= iCoreHash;
                  timeoutFlag <= 1'b0;
               end else if (timeoutHit) begin
                  oHash       <= '0;
                  timeoutFlag <= 1'b1;
               end
            end
            DONE: begin
               // Just-served requester drops to lowest priority
               ptr         <= winIdx;
               oGrant      <= '0;
               timeoutFlag <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign oBusy      = (state != IDLE);
   assign oCoreStart = (state == START);
   assign oDone      = (state == DONE) ? oGrant : '0;
   assign oTimeout   = (state == DONE) && timeoutFlag;

endmodule

// File: tb/tb_sha_core_arbiter.sv
// Directed bench for sha_core_arbiter; the bench itself plays the sha_core.
module tb_sha_core_arbiter;

   localparam int NUM_REQ = 2;
   localparam int TMO     = 16;

   logic                iClk = 1'b0;
   logic                iReset_n;
   logic [NUM_REQ-1:0]  iReq;
   logic [NUM_REQ*512-1:0] iMsg;
   logic [NUM_REQ-1:0]  oGrant, oDone;
   logic [255:0]        oHash;
   logic                oBusy, oTimeout, oCoreStart;
   logic [511:0]        oCoreMessage;
   logic [255:0]        iCoreHash;
   logic                iCoreValid;

   int checks = 0;
   int errors = 0;
   int startCnt = 0;
   int doneCnt = 0;

   localparam logic [511:0] MSG_ABC = {32'h61626380, 416'h0, 64'h18};
   localparam logic [511:0] MSG_A   = {16{32'hA5A5_0001}};
   localparam logic [511:0] MSG_B   = {16{32'h5A5A_0002}};
   localparam logic [255:0] HASH_ABC =
      256'hBA7816BF_8F01CFEA_414140DE_5DAE2223_B00361A3_96177A9C_B410FF61_F20015AD;

   sha_core_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TMO)) dut (
      .iClk         (iClk),
      .iReset_n     (iReset_n),
      .iReq         (iReq),
      .iMsg         (iMsg),
      .oGrant       (oGrant),
      .oDone        (oDone),
      .oHash        (oHash),
      .oBusy        (oBusy),
      .oTimeout     (oTimeout),
      .oCoreStart   (oCoreStart),
      .oCoreMessage (oCoreMessage),
      .iCoreHash    (iCoreHash),
      .iCoreValid   (iCoreValid)
   );

   always #5 iClk = ~iClk;

   always @(negedge iClk) begin
      if (oCoreStart) startCnt++;
      if (|oDone) doneCnt++;
   end

   task automatic checkVal(input string tag, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   // Entered in the IDLE cycle where iReq is already set (cycle 0); valid asserted
   // in cycle 2+lat. Returns in the IDLE cycle after DONE.
   task automatic doOp(input int idx, input logic [511:0] msg, input logic [255:0] hash,
                       input int lat, input bit keepLevel, input logic [1:0] nextReq);
      logic [1:0] g;
      int k;
      g = 2'b01 << idx;
      k = 2 + lat;
      tick();
      checkVal("load_grant", oGrant, g);
      checkVal("load_start", oCoreStart, 1'b0);
      checkVal("load_busy", oBusy, 1'b1);
      tick();
      checkVal("start_pulse", oCoreStart, 1'b1);
      checkVal("start_msg", oCoreMessage, msg);
      tick();
      checkVal("blank_done", oDone, 2'b00);
      checkVal("wait_start", oCoreStart, 1'b0);
      iCoreValid = 1'b0;
      for (int c = 4; c < k; c++) begin
         tick();
         checkVal("wait_nodone", oDone, 2'b00);
      end
      tick();
      iCoreValid = 1'b1;
      iCoreHash  = hash;
      tick();
      checkVal("done_pulse", oDone, g);
      checkVal("done_hash", oHash, hash);
      checkVal("done_grant", oGrant, g);
      checkVal("done_tmo", oTimeout, 1'b0);
      if (!keepLevel) iCoreValid = 1'b0;
      iReq = nextReq;
      tick();
      checkVal("idle_done", oDone, 2'b00);
      checkVal("idle_busy", oBusy, 1'b0);
      checkVal("idle_grant", oGrant, 2'b00);
      checkVal("idle_msg_hold", oCoreMessage, msg);
      checkVal("idle_hash_hold", oHash, hash);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, d0;
      iReset_n   = 1'b0;
      iReq       = '0;
      iMsg       = '0;
      iCoreHash  = '0;
      iCoreValid = 1'b0;
      repeat (2) tick();
      checkVal("rst_grant", oGrant, 2'b00);
      checkVal("rst_done", oDone, 2'b00);
      checkVal("rst_hash", oHash, 256'h0);
      checkVal("rst_busy", oBusy, 1'b0);
      checkVal("rst_tmo", oTimeout, 1'b0);
      checkVal("rst_start", oCoreStart, 1'b0);
      checkVal("rst_msg", oCoreMessage, 512'h0);
      iReset_n = 1'b1;
      tick();

      // Single requester, "abc" block, valid 64 cycles after start
      iMsg = {MSG_B, MSG_ABC};
      iReq = 2'b01;
      s0 = startCnt;
      d0 = doneCnt;
      doOp(0, MSG_ABC, HASH_ABC, 64, 1'b0, 2'b00);
      checkVal("abc_start_count", 32'(startCnt - s0), 32'd1);
      checkVal("abc_done_count", 32'(doneCnt - d0), 32'd1);

      // Mid-operation reset: requester 1 granted, reset in WAIT
      iReq = 2'b10;
      tick();
      checkVal("mid_grant", oGrant, 2'b10);
      repeat (3) tick();
      checkVal("mid_inwait", oBusy, 1'b1);
      d0 = doneCnt;
      #2;
      iReset_n = 1'b0;
      iReq     = 2'b00;
      #1;
      checkVal("mid_rst_busy", oBusy, 1'b0);
      checkVal("mid_rst_grant", oGrant, 2'b00);
      checkVal("mid_rst_hash", oHash, 256'h0);
      checkVal("mid_rst_msg", oCoreMessage, 512'h0);
      repeat (2) tick();
      iReset_n = 1'b1;
      tick();
      checkVal("mid_no_done", 32'(doneCnt - d0), 32'd0);

      // Contention: both requesting continuously, grants alternate from 0
      iMsg = {MSG_B, MSG_A};
      iReq = 2'b11;
      doOp(0, MSG_A, {8{32'h1111_0000}}, 2, 1'b0, 2'b11);
      doOp(1, MSG_B, {8{32'h2222_0000}}, 5, 1'b0, 2'b11);
      doOp(0, MSG_A, {8{32'h3333_0000}}, 3, 1'b0, 2'b11);
      doOp(1, MSG_B, {8{32'h4444_0000}}, 2, 1'b0, 2'b00);

      // Stale level valid carried into the next operation's blank cycle
      iReq = 2'b01;
      doOp(0, MSG_A, {8{32'h5555_0000}}, 3, 1'b1, 2'b01);
      checkVal("stale_valid_high", iCoreValid, 1'b1);
      doOp(0, MSG_A, {8{32'h6666_0000}}, 6, 1'b0, 2'b00);

      // Watchdog: valid never arrives
      iCoreHash = {8{32'h7777_0000}};
      iReq = 2'b01;
      d0 = doneCnt;
      tick();
      tick();
`ifdef SHA_ARB_TIMEOUT_EN
      for (int c = 3; c <= 2 + TMO; c++) begin
         tick();
         checkVal("tmo_waiting", oDone, 2'b00);
      end
      iReq = 2'b00;
      tick();
      checkVal("tmo_done", oDone, 2'b01);
      checkVal("tmo_flag", oTimeout, 1'b1);
      checkVal("tmo_hash", oHash, 256'h0);
      tick();
      checkVal("tmo_flag_clear", oTimeout, 1'b0);
      checkVal("tmo_idle", oBusy, 1'b0);
`else
      repeat (100) tick();
      checkVal("notmo_busy", oBusy, 1'b1);
      checkVal("notmo_flag", oTimeout, 1'b0);
      checkVal("notmo_no_done", 32'(doneCnt - d0), 32'd0);
      iReset_n = 1'b0;
      iReq     = 2'b00;
      tick();
      iReset_n = 1'b1;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
